// File: rtl/button_in_port_if.sv
// KCPSM6 port-bus signals shared between the processor and the button input port.
interface button_in_port_if;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;

  modport master (
    output port_id,
    output read_strobe,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  port_id,
    input  read_strobe,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/button_in_port.sv
// Synchronised, debounced push-button input port for KCPSM6 with sticky
// rising-edge flags (clear-on-read) and a level interrupt.
module button_in_port #(
  parameter int unsigned NUM_INPUTS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [7:0]  BASE_ADDR       = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] btn_in,
  output logic [NUM_INPUTS-1:0] btn_state,
  button_in_port_if.slave       bus
);

  localparam int unsigned   CNT_W      = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    ADDR_STATE = BASE_ADDR;
  localparam logic [7:0]    ADDR_FLAGS = 8'(BASE_ADDR + 8'd1);
  localparam logic [7:0]    ADDR_RAW   = 8'(BASE_ADDR + 8'd2);

  logic [NUM_INPUTS-1:0] s1;
  logic [NUM_INPUTS-1:0] s2;
  logic [NUM_INPUTS-1:0] deb;
  logic [NUM_INPUTS-1:0] flags;
  logic [CNT_W-1:0]      cnt [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] deb_nxt_c;
  logic [CNT_W-1:0]      cnt_nxt_c [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] rise_c;
  logic [NUM_INPUTS-1:0] flags_nxt_c;
  logic                  rd_clear_c;
  logic [7:0]            rd_data_c;

  // Per-input debounce: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    deb_nxt_c = deb;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      cnt_nxt_c[i] = cnt[i];
      if (s2[i] == deb[i]) begin
        cnt_nxt_c[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        deb_nxt_c[i] = s2[i];
        cnt_nxt_c[i] = '0;
      end else begin
        cnt_nxt_c[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Flag update and read mux; a clear only drops bits the processor actually received.
  always_comb begin
    rise_c      = deb_nxt_c & ~deb;
    rd_clear_c  = bus.read_strobe && (bus.port_id == ADDR_FLAGS);
    flags_nxt_c = flags | rise_c;
    if (rd_clear_c) begin
      flags_nxt_c = (flags & ~bus.in_port[NUM_INPUTS-1:0]) | rise_c;
    end

    rd_data_c = 8'h00;
    if (bus.port_id == ADDR_STATE) begin
      rd_data_c = 8'(deb);
    end else if (bus.port_id == ADDR_FLAGS) begin
      rd_data_c = 8'(flags);
    end else if (bus.port_id == ADDR_RAW) begin
      rd_data_c = 8'(s2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1            <= '0;
      s2            <= '0;
      deb           <= '0;
      flags         <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        cnt[i] <= '0;
      end
      bus.in_port   <= 8'h00;
      bus.interrupt <= 1'b0;
    end else begin
      s1            <= btn_in;
      s2            <= s1;
      deb           <= deb_nxt_c;
      flags         <= flags_nxt_c;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        cnt[i] <= cnt_nxt_c[i];
      end
      bus.in_port   <= rd_data_c;
      bus.interrupt <= |flags;
    end
  end

  assign btn_state = deb;

endmodule

// File: tb/tb_button_in_port.sv
// Self-checking bench for button_in_port: directed scenarios with literal
// expectations plus randomized traffic checked against a window-based model.
module tb_button_in_port;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_state;
  logic         chk_en = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  button_in_port_if bus ();

  button_in_port #(
    .NUM_INPUTS     (N),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR      (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_state(btn_state),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: s2 is a two-stage delay of the pin; a debounced bit flips
  // when its last DEB s2 samples all disagree with the current debounced value.
  logic [N-1:0]   m_s1 = '0, m_s2 = '0, m_deb = '0, m_flags = '0;
  logic [DEB-1:0] m_hist [N];
  logic [7:0]     m_in_port = 8'h00;
  logic           m_int = 1'b0;

  logic [N-1:0]   n_deb, n_flags, n_rise;
  logic [DEB-1:0] n_hist [N];
  logic [7:0]     n_in_port;

  always_comb begin
    n_deb = m_deb;
    for (int i = 0; i < int'(N); i++) begin
      n_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
      if (n_hist[i] == {DEB{~m_deb[i]}}) n_deb[i] = ~m_deb[i];
    end
    n_rise  = n_deb & ~m_deb;
    n_flags = m_flags | n_rise;
    if (bus.read_strobe && bus.port_id == 8'h01)
      n_flags = (m_flags & ~m_in_port[N-1:0]) | n_rise;
    case (bus.port_id)
      8'h00:   n_in_port = {4'h0, m_deb};
      8'h01:   n_in_port = {4'h0, m_flags};
      8'h02:   n_in_port = {4'h0, m_s2};
      default: n_in_port = 8'h00;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_deb <= '0; m_flags <= '0;
      m_in_port <= 8'h00; m_int <= 1'b0;
      for (int i = 0; i < int'(N); i++) m_hist[i] <= '0;
    end else begin
      m_s1 <= btn_in; m_s2 <= m_s1; m_deb <= n_deb; m_flags <= n_flags;
      m_in_port <= n_in_port; m_int <= |m_flags;
      for (int i = 0; i < int'(N); i++) m_hist[i] <= n_hist[i];
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_port",   bus.in_port,               m_in_port);
      check("model_interrupt", {7'd0, bus.interrupt},     {7'd0, m_int});
      check("model_btn_state", {4'd0, btn_state},         {4'd0, m_deb});
    end
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_negs(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int sel;
    bus.port_id     = 8'h00;
    bus.read_strobe = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    wait_negs(3);
    reset = 1'b1;
    wait_negs(2);
    check("rst_in_port", bus.in_port, 8'h00);
    check("rst_btn_state", {4'd0, btn_state}, 8'h00);

    // Glitch: 3 high, 1 low, 3 high never reaches 4 stable samples.
    btn_in = 4'b0010; wait_negs(3);
    btn_in = 4'b0000; wait_negs(1);
    btn_in = 4'b0010; wait_negs(3);
    btn_in = 4'b0000; wait_negs(8);
    check("glitch_state", {4'd0, btn_state}, 8'h00);
    check("glitch_irq", {7'd0, bus.interrupt}, 8'h00);

    // Debounce latency: accepted at edge 6, interrupt at edge 7.
    btn_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      edge_sample();
      if (e == 5) check("deb_e5_state", {4'd0, btn_state}, 8'h00);
      if (e == 6) begin
        check("deb_e6_state", {4'd0, btn_state}, 8'h01);
        check("deb_e6_irq", {7'd0, bus.interrupt}, 8'h00);
      end
      if (e == 7) check("deb_e7_irq", {7'd0, bus.interrupt}, 8'h01);
    end

    // Clear-on-read of flags.
    @(negedge clk); bus.port_id = 8'h01; bus.read_strobe = 1'b0;
    edge_sample(); check("cor_data", bus.in_port, 8'h01);
    @(negedge clk); bus.read_strobe = 1'b1;
    edge_sample(); check("cor_irq_hold", {7'd0, bus.interrupt}, 8'h01);
    @(negedge clk); bus.read_strobe = 1'b0;
    edge_sample();
    check("cor_irq_drop", {7'd0, bus.interrupt}, 8'h00);
    check("cor_reread", bus.in_port, 8'h00);

    // Re-arm bit0, then let bit2 rise on the clearing edge.
    @(negedge clk); btn_in = 4'b0000; wait_negs(8);
    btn_in = 4'b0001; wait_negs(8);
    check("sim_pre_flags", bus.in_port, 8'h01);
    btn_in = 4'b0101;
    for (int e = 1; e <= 5; e++) edge_sample();
    @(negedge clk); bus.read_strobe = 1'b1;
    edge_sample();
    check("sim_read", bus.in_port, 8'h01);
    check("sim_state", {4'd0, btn_state}, 8'h05);
    @(negedge clk); bus.read_strobe = 1'b0;
    edge_sample();
    check("sim_reread", bus.in_port, 8'h04);
    check("sim_irq", {7'd0, bus.interrupt}, 8'h01);
    @(negedge clk); bus.read_strobe = 1'b1;
    @(negedge clk); bus.read_strobe = 1'b0;

    // Port mux.
    bus.port_id = 8'h00;
    edge_sample(); check("mux_state", bus.in_port, 8'h05);
    @(negedge clk); btn_in = 4'b1010; wait_negs(3);
    bus.port_id = 8'h02;
    edge_sample(); check("mux_raw", bus.in_port, 8'h0A);
    @(negedge clk); bus.port_id = 8'h03;
    edge_sample(); check("mux_p03", bus.in_port, 8'h00);
    @(negedge clk); bus.port_id = 8'h7F;
    edge_sample(); check("mux_p7f", bus.in_port, 8'h00);

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        btn_in = N'($urandom);
        hold   = int'($urandom_range(1, 10));
      end
      hold--;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2: bus.port_id = 8'(sel);
        3:       bus.port_id = 8'h01;
        4:       bus.port_id = 8'h03;
        default: bus.port_id = 8'($urandom);
      endcase
      bus.read_strobe = 1'($urandom);
    end

    // Asynchronous reset mid-run with non-zero outputs.
    @(negedge clk); btn_in = 4'b1111; bus.port_id = 8'h00; bus.read_strobe = 1'b0;
    wait_negs(10);
    check("pre_rst_state", {4'd0, btn_state}, 8'h0F);
    #2 reset = 1'b0;
    #1;
    check("async_in_port", bus.in_port, 8'h00);
    check("async_irq", {7'd0, bus.interrupt}, 8'h00);
    check("async_state", {4'd0, btn_state}, 8'h00);
    btn_in = 4'b0000;
    @(negedge clk); reset = 1'b1;
    wait_negs(4);
    check("post_rst_in_port", bus.in_port, 8'h00);
    check("post_rst_irq", {7'd0, bus.interrupt}, 8'h00);
    check("post_rst_state", {4'd0, btn_state}, 8'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
